// File: rtl/neuron_layer_sched.sv
// Shares one combinational neuron MAC across n_neurons leaky integrate-and-fire neurons.
// Latency: a frame accepted at edge 0 raises out_valid at edge 2*n_neurons+1, two cycles per neuron.
// Backpressure: in_ready only in IDLE; out_valid/out_spikes are held until out_ready.
module neuron_layer_sched #(
  parameter int n_size    = 8,
  parameter int b_size    = 8,
  parameter int n_neurons = 4,
  parameter int o_size    = 2*n_size + b_size/2,
  localparam int aw       = (n_neurons > 1) ? $clog2(n_neurons) : 1,
  localparam int dw       = b_size*n_size
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dw-1:0]        in_data,
  output logic                 w_rd_en,
  output logic [aw-1:0]        w_addr,
  input  logic [dw-1:0]        w_rd_data,
  output logic [dw-1:0]        mac_data_in,
  output logic [dw-1:0]        mac_weights,
  input  logic [o_size-1:0]    mac_result,
  input  logic [o_size-1:0]    threshold,
  input  logic [3:0]           leak_sh,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [n_neurons-1:0] out_spikes,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

  state_t                state, state_nxt;
  logic [dw-1:0]         data_q;
  logic [o_size-1:0]     thr_q;
  logic [3:0]            leak_q;
  logic [aw-1:0]         k_q;
  logic [n_neurons-1:0]  spike_q;
  logic                  out_valid_q;
  logic [o_size-1:0]     v_mem [n_neurons];

  logic                  last_k;
  logic                  accept;
  logic [o_size-1:0]     v_cur;
  logic [o_size-1:0]     leak_amt;
  logic [o_size:0]       v_sum;
  logic [o_size-1:0]     v_sat;
  logic                  fire;

  assign last_k = (k_q == aw'(n_neurons - 1));
  assign accept = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = FETCH;
      FETCH:   state_nxt = MAC;
      MAC:     state_nxt = last_k ? DONE : FETCH;
      DONE:    if (out_valid_q && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign w_rd_en     = (state == FETCH);
  assign w_addr      = (state == FETCH) ? k_q : '0;
  assign mac_data_in = (state == MAC) ? data_q : '0;
  assign mac_weights = (state == MAC) ? w_rd_data : '0;
  assign out_valid   = out_valid_q;
  assign out_spikes  = out_valid_q ? spike_q : '0;

  // The subtraction cannot underflow since leak <= v; only the add can overflow.
  assign v_cur    = v_mem[k_q];
  assign leak_amt = (leak_q == 4'd0) ? '0 : (v_cur >> leak_q);
  assign v_sum    = {1'b0, v_cur} - {1'b0, leak_amt} + {1'b0, mac_result};
  assign v_sat    = v_sum[o_size] ? {o_size{1'b1}} : v_sum[o_size-1:0];
  assign fire     = (v_sat >= thr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_q      <= '0;
      thr_q       <= '0;
      leak_q      <= '0;
      k_q         <= '0;
      spike_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < n_neurons; i++) v_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q  <= in_data;
        thr_q   <= threshold;
        leak_q  <= leak_sh;
        k_q     <= '0;
        spike_q <= '0;
      end
      if (state == MAC) begin
        v_mem[k_q] <= fire ? '0 : v_sat;
        if (fire) spike_q[k_q] <= 1'b1;
        if (!last_k) k_q <= k_q + 1'b1;
      end
      // out_valid rises one cycle into DONE and drops after the handshake
      if (state == DONE) out_valid_q <= !(out_valid_q && out_ready);
    end
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Bench for neuron_layer_sched: models weight memory and MAC, scoreboards spike vectors
// against an independent membrane model.
module tb_neuron_layer_sched;

  localparam int NS = 8, BS = 4, NN = 4, OS = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          w_rd_en;
  logic [1:0]    w_addr;
  logic [31:0]   w_rd_data = '0;
  logic [31:0]   mac_data_in;
  logic [31:0]   mac_weights;
  logic [17:0]   mac_result;
  logic [17:0]   threshold = '0;
  logic [3:0]    leak_sh = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_spikes;
  logic          busy;

  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic          sat_mode = 1'b0;
  logic [17:0]   model_v [NN];
  logic [3:0]    exp_q [$];
  int            addr_log [$];

  neuron_layer_sched #(.n_size(NS), .b_size(BS), .n_neurons(NN), .o_size(OS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .mac_data_in(mac_data_in), .mac_weights(mac_weights), .mac_result(mac_result),
    .threshold(threshold), .leak_sh(leak_sh), .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous weight memory: row k lanes = k+1, or all 255 in saturation mode
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_rd_data <= sat_mode ? {4{8'd255}} : {4{8'(w_addr + 2'd1)}};
      addr_log.push_back(int'(w_addr));
    end
  end

  always_comb begin
    mac_result = '0;
    for (int i = 0; i < BS; i++)
      mac_result = mac_result + 18'(mac_data_in[i*NS +: NS]) * 18'(mac_weights[i*NS +: NS]);
  end

  task automatic model_clear();
    for (int i = 0; i < NN; i++) model_v[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_frame(input int lane, input logic [17:0] thr, input logic [3:0] lsh);
    logic [3:0]  sp;
    logic [18:0] vn;
    logic [17:0] lk, m;
    sp = '0;
    for (int k = 0; k < NN; k++) begin
      m  = sat_mode ? 18'(4*lane*255) : 18'(4*lane*(k+1));
      lk = (lsh == 0) ? 18'd0 : (model_v[k] >> lsh);
      vn = 19'(model_v[k]) - 19'(lk) + 19'(m);
      if (vn > 19'h3ffff) vn = 19'h3ffff;
      if (vn[17:0] >= thr) begin sp[k] = 1'b1; model_v[k] = '0; end
      else model_v[k] = vn[17:0];
    end
    exp_q.push_back(sp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // returns #1 after the accepting edge
  task automatic start_frame(input int lane, input logic [17:0] thr, input logic [3:0] lsh);
    int guard;
    @(negedge clk);
    in_data = {4{8'(lane)}};
    threshold = thr;
    leak_sh = lsh;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_frame(lane, thr, lsh);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      total_cnt++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic recv();
    logic [3:0] e;
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) $display("FAIL scoreboard_empty: out_spikes=%b with no expected entry", out_spikes);
    else begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || out_spikes !== e)
        $display("FAIL spikes: out_valid=%b out_spikes=%b, required 1/%b", out_valid, out_spikes, e);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic check_mem(input string name);
    logic [17:0] dv;
    for (int i = 0; i < NN; i++) begin
      dv = dut.v_mem[i];
      total_cnt++;
      if (dv !== model_v[i]) $display("FAIL %s_v%0d: got %0d, required %0d", name, i, dv, model_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_rd_en !== 1'b0 || w_addr !== 2'd0 ||
        out_spikes !== 4'd0 || mac_data_in !== '0 || mac_weights !== '0 || busy !== 1'b0)
      $display("FAIL %s: rdy=%b ov=%b ren=%b addr=%0d sp=%b din=%h w=%h busy=%b, required 1 0 0 0 0000 0 0 0",
               name, in_ready, out_valid, w_rd_en, w_addr, out_spikes, mac_data_in, mac_weights, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_outputs");
    do_reset();
    check_idle_outputs("after_reset_release");
    check_mem("reset_mem");
  endtask

  task automatic test_basic();
    int lat;
    addr_log.delete();
    start_frame(1, 18'd10, 4'd0);
    wait_out(lat);
    total_cnt++;
    if (lat !== 9) $display("FAIL latency: got %0d cycles, required 9", lat);
    else pass_cnt++;
    total_cnt++;
    if (out_spikes !== 4'b1100) $display("FAIL basic_spikes_const: got %b, required 1100", out_spikes);
    else pass_cnt++;
    recv();
    check_mem("basic");
    total_cnt++;
    if (addr_log.size() != 4 || addr_log[0] != 0 || addr_log[1] != 1 || addr_log[2] != 2 || addr_log[3] != 3)
      $display("FAIL w_addr_seq: got %p, required '{0,1,2,3}", addr_log);
    else pass_cnt++;
  endtask

  task automatic test_second();
    int lat;
    start_frame(1, 18'd10, 4'd0);
    wait_out(lat);
    total_cnt++;
    if (out_spikes !== 4'b1110) $display("FAIL second_spikes_const: got %b, required 1110", out_spikes);
    else pass_cnt++;
    recv();
    check_mem("second");
  endtask

  task automatic test_leak();
    int lat;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      start_frame(1, 18'd100, 4'd1);
      wait_out(lat);
      recv();
      check_mem("leak");
    end
    total_cnt++;
    if (dut.v_mem[0] !== 18'd6 || dut.v_mem[3] !== 18'd24)
      $display("FAIL leak_const: v0=%0d v3=%0d, required 6 24", dut.v_mem[0], dut.v_mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] held;
    start_frame(1, 18'd10, 4'd0);
    wait_out(lat);
    held = out_spikes;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 2);
      in_data = {4{8'd9}};
      total_cnt++;
      if (out_valid !== 1'b1 || out_spikes !== held || in_ready !== 1'b0)
        $display("FAIL backpressure_hold: ov=%b sp=%b rdy=%b, required 1 %b 0", out_valid, out_spikes, in_ready, held);
      else pass_cnt++;
    end
    @(negedge clk) in_valid = 1'b0;
    recv();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ignored_in_valid: busy=%b, required 0", busy);
    else pass_cnt++;
    check_mem("backpressure");
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    start_frame(1, 18'd10, 4'd0);
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (mac_weights !== {4{8'd3}}) $display("FAIL mid_in_mac2: mac_weights=%h, required 03030303", mac_weights);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset_outputs");
    model_clear();
    check_mem("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    start_frame(1, 18'd10, 4'd0);
    wait_out(lat);
    total_cnt++;
    if (out_spikes !== 4'b1100) $display("FAIL mid_reset_refire: got %b, required 1100", out_spikes);
    else pass_cnt++;
    recv();
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    sat_mode = 1'b1;
    for (int f = 0; f < 2; f++) begin
      start_frame(255, 18'h3ffff, 4'd0);
      wait_out(lat);
      if (f == 1) begin
        total_cnt++;
        if (out_spikes !== 4'b1111) $display("FAIL saturation_const: got %b, required 1111", out_spikes);
        else pass_cnt++;
      end
      recv();
      check_mem("saturation");
    end
    sat_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_second();
    test_leak();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
